// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the mips run controller: FSM encoding and halt-reason codes.
package cpu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RSEQ = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    TOUT = 3'd4
  } run_state_t;

  typedef enum logic [1:0] {
    HR_NONE    = 2'd0,
    HR_HALT    = 2'd1,
    HR_TIMEOUT = 2'd2
  } halt_reason_t;

  function automatic halt_reason_t halt_reason(input logic done, input logic timeout);
    halt_reason_t r;
    r = HR_NONE;
    if (done)
      r = HR_HALT;
    else if (timeout)
      r = HR_TIMEOUT;
    return r;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_halt_detector.sv
// Self-loop halt detection: flags the commit that makes the same PC retire STALL_LIMIT times in a row.
module halt_detector
  import cpu_run_ctrl_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int STALL_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic            commit_valid,
  input  logic [PC_W-1:0] commit_pc,
  output logic            halt
);

  localparam int REP_W = $clog2(STALL_LIMIT + 1);
  localparam logic [REP_W-1:0] REP_LIM = REP_W'(STALL_LIMIT);

  logic [PC_W-1:0]  last_pc;
  logic [REP_W-1:0] rep;
  logic [REP_W-1:0] rep_nxt;
  logic             hit;

  // rep == 0 marks "no commit yet this run", so the first commit always starts a fresh streak
  always_comb begin
    hit     = (rep != '0) && (commit_pc == last_pc);
    rep_nxt = REP_W'(1);
    if (hit)
      rep_nxt = (rep == REP_LIM) ? rep : rep + REP_W'(1);
    halt = en && commit_valid && (rep_nxt == REP_LIM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_pc <= '0;
      rep     <= '0;
    end else if (clr) begin
      last_pc <= '0;
      rep     <= '0;
    end else if (en && commit_valid) begin
      last_pc <= commit_pc;
      rep     <= rep_nxt;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the pipelined mips core: sequenced core reset, cycle/commit counters,
// halt and cycle-budget timeout detection with registered status outputs.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 1,
  parameter int STALL_LIMIT = 4,
  parameter int MAX_CYCLES  = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             commit_valid,
  input  logic [PC_W-1:0]  commit_pc,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] commit_count
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_MAX = CNT_W'(MAX_CYCLES);

  run_state_t       state_q, state_n;
  logic [RC_W-1:0]  rcnt_q, rcnt_n;
  logic [CNT_W-1:0] cyc_n, cmt_n;
  logic             halt;

  halt_detector #(
    .PC_W        (PC_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_halt (
    .clk          (clk),
    .reset        (reset),
    .clr          (clear),
    .en           (state_q == RUN),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .halt         (halt)
  );

  always_comb begin
    state_n = state_q;
    rcnt_n  = rcnt_q;
    cyc_n   = cycle_count;
    cmt_n   = commit_count;
    if (clear) begin
      state_n = IDLE;
      rcnt_n  = '0;
      cyc_n   = '0;
      cmt_n   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_n = RSEQ;
            rcnt_n  = RC_LOAD;
          end
        end
        RSEQ: begin
          if (rcnt_q == '0)
            state_n = RUN;
          else
            rcnt_n = rcnt_q - RC_W'(1);
        end
        RUN: begin
          cyc_n = cycle_count + CNT_W'(1);
          if (commit_valid)
            cmt_n = commit_count + CNT_W'(1);
          // halt takes priority when both end conditions land on the same edge
          if (halt)
            state_n = DONE;
          else if (cyc_n == CYC_MAX)
            state_n = TOUT;
        end
        DONE, TOUT: state_n = state_q;
        default:    state_n = IDLE;
      endcase
    end
  end

  // Status outputs are decoded from the next state so they change on the same edge as the FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rcnt_q       <= '0;
      cycle_count  <= '0;
      commit_count <= '0;
      core_reset   <= 1'b1;
      running      <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state_q      <= state_n;
      rcnt_q       <= rcnt_n;
      cycle_count  <= cyc_n;
      commit_count <= cmt_n;
      core_reset   <= (state_n == IDLE) || (state_n == RSEQ);
      running      <= (state_n == RUN);
      done         <= (state_n == DONE);
      timeout      <= (state_n == TOUT);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: vector table for halt/timeout/priority runs plus hand sequences.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  localparam logic [3:0] F_IDLE = 4'b1000;
  localparam logic [3:0] F_RUN  = 4'b0100;
  localparam logic [3:0] F_DONE = 4'b0010;
  localparam logic [3:0] F_TOUT = 4'b0001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = '0;

  logic        cr1, run1, dn1, to1;
  logic [31:0] cc1, cm1;
  logic        cr0, run0, dn0, to0;
  logic [31:0] cc0, cm0;

  cpu_run_ctrl #(
    .PC_W(32), .CNT_W(32), .RST_CYCLES(3), .STALL_LIMIT(4), .MAX_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .core_reset(cr1), .running(run1), .done(dn1), .timeout(to1),
    .cycle_count(cc1), .commit_count(cm1)
  );

  cpu_run_ctrl dut0 (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .core_reset(cr0), .running(run0), .done(dn0), .timeout(to0),
    .cycle_count(cc0), .commit_count(cm0)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        st;
    logic        cl;
    logic        cv;
    logic [31:0] pc;
    logic [3:0]  fl;
    logic [31:0] cc;
    logic [31:0] cm;
  } vec_t;

  vec_t         vecs[$];
  int           n_vec = 0;
  int           n_bad = 0;
  halt_reason_t last_reason = HR_NONE;

  task automatic add(input string nm, input logic st, input logic cl, input logic cv,
                     input logic [31:0] pc, input logic [3:0] fl,
                     input logic [31:0] cc, input logic [31:0] cm);
    vec_t v;
    v.nm = nm; v.st = st; v.cl = cl; v.cv = cv; v.pc = pc;
    v.fl = fl; v.cc = cc; v.cm = cm;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string nm, input logic [3:0] af, input logic [31:0] acc,
                     input logic [31:0] acm, input logic [3:0] ef,
                     input logic [31:0] ecc, input logic [31:0] ecm);
    n_vec++;
    if (af !== ef || acc !== ecc || acm !== ecm) begin
      n_bad++;
      $display("FAIL %s: got flags(cr,run,dn,to)=%b cycles=%0d commits=%0d, want flags=%b cycles=%0d commits=%0d",
               nm, af, acc, acm, ef, ecc, ecm);
    end
  endtask

  task automatic drive(input logic st, input logic cl, input logic cv, input logic [31:0] pc);
    start = st; clear = cl; commit_valid = cv; commit_pc = pc;
  endtask

  task automatic apply(input logic st, input logic cl, input logic cv, input logic [31:0] pc);
    drive(st, cl, cv, pc);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // halt run: RST_CYCLES=3, STALL_LIMIT=4
    add("h_start",     1, 0, 0, 32'h0000, F_IDLE, 0, 0);
    add("h_rseq1",     0, 0, 1, 32'h3008, F_IDLE, 0, 0);
    add("h_rseq2",     0, 0, 1, 32'h3008, F_IDLE, 0, 0);
    add("h_run0",      0, 0, 1, 32'h3008, F_RUN,  0, 0);
    add("h_c3000",     0, 0, 1, 32'h3000, F_RUN,  1, 1);
    add("h_c3004",     0, 0, 1, 32'h3004, F_RUN,  2, 2);
    add("h_start_ign", 1, 0, 0, 32'h3008, F_RUN,  3, 2);
    add("h_novalid1",  0, 0, 0, 32'h9999, F_RUN,  4, 2);
    add("h_rep1",      0, 0, 1, 32'h3008, F_RUN,  5, 3);
    add("h_rep2",      0, 0, 1, 32'h3008, F_RUN,  6, 4);
    add("h_novalid2",  0, 0, 0, 32'h1234, F_RUN,  7, 4);
    add("h_rep3",      0, 0, 1, 32'h3008, F_RUN,  8, 5);
    add("h_rep4_halt", 0, 0, 1, 32'h3008, F_DONE, 9, 6);
    add("h_frz_start", 1, 0, 1, 32'h3008, F_DONE, 9, 6);
    add("h_frz",       0, 0, 0, 32'h0000, F_DONE, 9, 6);
    add("h_clr_start", 1, 1, 0, 32'h0000, F_IDLE, 0, 0);
    for (int k = 1; k <= 3; k++)
      add($sformatf("h_no_rseq%0d", k), 0, 0, 0, 32'h0, F_IDLE, 0, 0);

    // timeout run: MAX_CYCLES=20, all PCs distinct
    add("t_start", 1, 0, 0, 32'h0, F_IDLE, 0, 0);
    add("t_rseq1", 0, 0, 1, 32'h0, F_IDLE, 0, 0);
    add("t_rseq2", 0, 0, 1, 32'h0, F_IDLE, 0, 0);
    add("t_run0",  0, 0, 1, 32'h0, F_RUN,  0, 0);
    for (int k = 1; k <= 20; k++)
      add($sformatf("t_cyc%0d", k), 0, 0, 1, 32'h100 + 32'(4 * k),
          (k == 20) ? F_TOUT : F_RUN, 32'(k), 32'(k));
    add("t_frz", 1, 0, 1, 32'h200, F_TOUT, 20, 20);
    add("t_clr", 0, 1, 0, 32'h0,   F_IDLE, 0, 0);

    // 4th repeat on the edge the budget is reached
    add("s_start", 1, 0, 0, 32'h0, F_IDLE, 0, 0);
    add("s_rseq1", 0, 0, 0, 32'h0, F_IDLE, 0, 0);
    add("s_rseq2", 0, 0, 0, 32'h0, F_IDLE, 0, 0);
    add("s_run0",  0, 0, 0, 32'h0, F_RUN,  0, 0);
    for (int k = 1; k <= 16; k++)
      add($sformatf("s_cyc%0d", k), 0, 0, 0, 32'h500, F_RUN, 32'(k), 0);
    for (int k = 17; k <= 20; k++)
      add($sformatf("s_cyc%0d", k), 0, 0, 1, 32'h500,
          (k == 20) ? F_DONE : F_RUN, 32'(k), 32'(k - 16));
    add("s_frz", 0, 0, 0, 32'h0, F_DONE, 20, 4);
    add("s_clr", 0, 1, 0, 32'h0, F_IDLE, 0, 0);

    // reset values
    reset = 1'b0;
    repeat (2) @(negedge clk);
    cmp("reset_dut",  {cr1, run1, dn1, to1}, cc1, cm1, F_IDLE, 0, 0);
    cmp("reset_dut0", {cr0, run0, dn0, to0}, cc0, cm0, F_IDLE, 0, 0);
    reset = 1'b1;
    @(negedge clk);

    // default parameters: one reset cycle, then free-running cycle count
    apply(1, 0, 0, 32'h0);
    cmp("d0_rseq", {cr0, run0, dn0, to0}, cc0, cm0, F_IDLE, 0, 0);
    apply(0, 0, 0, 32'h0);
    cmp("d0_run0", {cr0, run0, dn0, to0}, cc0, cm0, F_RUN, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      apply(0, 0, 0, 32'h0);
      cmp($sformatf("d0_cyc%0d", k), {cr0, run0, dn0, to0}, cc0, cm0, F_RUN, 32'(k), 0);
    end
    apply(0, 1, 0, 32'h0);
    cmp("d0_clear",  {cr0, run0, dn0, to0}, cc0, cm0, F_IDLE, 0, 0);
    cmp("dut_clear", {cr1, run1, dn1, to1}, cc1, cm1, F_IDLE, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].st, vecs[i].cl, vecs[i].cv, vecs[i].pc);
      cmp(vecs[i].nm, {cr1, run1, dn1, to1}, cc1, cm1, vecs[i].fl, vecs[i].cc, vecs[i].cm);
      if (halt_reason(dn1, to1) != HR_NONE)
        last_reason = halt_reason(dn1, to1);
    end

    // asynchronous reset in the middle of a run
    apply(1, 0, 0, 32'h0);
    apply(0, 0, 0, 32'h0);
    apply(0, 0, 0, 32'h0);
    apply(0, 0, 0, 32'h0);
    for (int k = 1; k <= 7; k++)
      apply(0, 0, 1, 32'h700 + 32'(4 * k));
    drive(0, 0, 0, 32'h0);
    cmp("mid_run_cc7", {cr1, run1, dn1, to1}, cc1, cm1, F_RUN, 7, 7);
    #2 reset = 1'b0;
    #1 cmp("async_reset", {cr1, run1, dn1, to1}, cc1, cm1, F_IDLE, 0, 0);
    @(negedge clk);
    cmp("reset_held", {cr1, run1, dn1, to1}, cc1, cm1, F_IDLE, 0, 0);
    reset = 1'b1;
    apply(0, 0, 1, 32'h800);
    cmp("post_reset_idle", {cr1, run1, dn1, to1}, cc1, cm1, F_IDLE, 0, 0);

    $display("last terminal reason: %s", last_reason.name());
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Parametrised run controller for simulating and bringing up the pipelined mips core.
- Replaces the fixed "hold reset one cycle, then free-run" stimulus with a sequenced core reset of configurable length.
- Adds cycle and commit counters, self-loop halt detection and a cycle-budget timeout, so benches and FPGA wrappers get a deterministic end-of-program signal.
- Sits between the board/bench clock-reset source and the core's reset input, and observes the core's writeback-stage commit stream.

Parameters:
- PC_W, 32: width of the observed commit PC.
- CNT_W, 32: width of cycle_count and commit_count.
- RST_CYCLES, 1: number of cycles core_reset stays asserted after start; legal range >= 1.
- STALL_LIMIT, 4: consecutive commits of the same PC that signal program halt; legal range >= 2.
- MAX_CYCLES, 100000: RUN-state cycle budget before timeout; legal range >= 1, must be < 2^CNT_W.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low: 0 resets the block immediately; release is synchronous to clk.
- start  in  1  single-cycle pulse; begins a run when the block is in IDLE.
- clear  in  1  synchronous return to IDLE from any state.
- commit_valid  in  1  core retired one instruction this cycle.
- commit_pc  in  PC_W  PC of the retired instruction; qualified by commit_valid.
- core_reset  out  1  active-high reset driven into the mips core.
- running  out  1  high while in RUN.
- done  out  1  sticky; halt detected.
- timeout  out  1  sticky; cycle budget exhausted.
- cycle_count  out  CNT_W  number of RUN cycles elapsed.
- commit_count  out  CNT_W  number of commits seen in RUN.

Behaviour:
- States: IDLE, RSEQ, RUN, DONE, TOUT.
- While reset=0, all outputs hold their reset values:
  - state IDLE, core_reset=1, running=0, done=0, timeout=0.
  - Counters 0, last_pc 0, repeat count 0.
  - Applies even when reset is asserted mid-run.
- IDLE: core_reset=1. start=1 moves to RSEQ and loads the reset counter with RST_CYCLES-1.
- RSEQ:
  - core_reset=1 and the counter decrements each cycle.
  - At counter 0, move to RUN next edge. core_reset is therefore high for exactly RST_CYCLES cycles after the start edge.
- RUN:
  - core_reset=0, running=1.
  - cycle_count increments every cycle. commit_count increments on commit_valid.
  - Commits before the first RUN cycle are ignored.
- Halt detection, on commit_valid in RUN:
  - If commit_pc == last_pc, increment rep. Otherwise set rep=1 and last_pc=commit_pc.
  - The first commit of a run always sets rep=1.
  - When rep reaches STALL_LIMIT, move to DONE. done=1 from the next cycle.
- Timeout: when the cycle_count update would reach MAX_CYCLES, move to TOUT. timeout=1 from the next cycle.
- Halt and timeout firing in the same cycle: DONE wins; timeout stays 0.
- DONE and TOUT:
  - core_reset stays 0 so core state remains inspectable.
  - running=0; counters frozen; done/timeout held.
  - start is ignored. Only clear or reset exits.
- clear=1 in any state moves to IDLE next edge and zeroes counters, rep, last_pc, done and timeout.
- clear and start in the same cycle: clear wins; start is ignored.
- start outside IDLE is ignored.
- Counters cannot wrap, because MAX_CYCLES < 2^CNT_W bounds cycle_count and commit_count <= cycle_count.
- Outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package cpu_run_ctrl_pkg holds:
  - The state encoding constants (IDLE=0, RSEQ=1, RUN=2, DONE=3, TOUT=4; 3-bit).
  - The halt-reason codes, reused by the bench summary printer.
- One natural sub-module: halt_detector. It contains last_pc, the rep counter and compare logic, and has inputs clk, reset, clr, en, commit_valid, commit_pc and output halt.
- The FSM and counters stay in cpu_run_ctrl.

Test Plan:
- Reset and default run: reset low 2 cycles, then high, start pulse → core_reset high 1 cycle (RST_CYCLES=1), running=1 next cycle, cycle_count increments 1,2,3…
- Halt detection: RST_CYCLES=3, STALL_LIMIT=4; commits at PC 0x3000, 0x3004, then 0x3008 ×4 → core_reset high 3 cycles, done=1 the cycle after the 4th 0x3008 commit, commit_count=6, counters frozen afterwards.
- Timeout: MAX_CYCLES=20, commits of distinct PCs → timeout=1 with cycle_count=20, done=0, running=0.
- Simultaneous events: the STALL_LIMIT-th repeat lands on the cycle the count reaches MAX_CYCLES → done=1, timeout=0. clear+start together in DONE → IDLE, all counters 0, no RSEQ.
- Reset mid-run: drive reset=0 asynchronously between edges during RUN with cycle_count=7 → core_reset=1, running=0, counters 0 immediately, without waiting for a clock edge.
- Ignored inputs: start during RUN and DONE → no state change. commit_valid=0 with changing commit_pc → rep and commit_count unchanged.
